// File: rtl/exu_stage.sv
// exu_stage: handshaked execute stage. Computes the ALU result, branch decision and target,
// and store byte mask for one decoded instruction, and registers them toward LSU/WBU.
// Optional iterative multiply/divide unit is built when EXU_MDU_EN is defined.
// Handshake: a transfer happens on a clock edge where valid && ready are both high. A
// producer holds valid and its payload steady until that edge, and ready may depend on
// the state but never on valid.
module exu_stage #(
   parameter int XLEN   = 32,
   parameter int MASK_W = XLEN / 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        alu_srca,
   input  logic [1:0]        alu_srcb,
   input  logic [3:0]        alu_ctrl,
   input  logic              is_mdu,
   input  logic [2:0]        mdu_op,
   input  logic [3:0]        branch_type,
   input  logic [2:0]        mem_width,
   input  logic [XLEN-1:0]   data_reg1,
   input  logic [XLEN-1:0]   data_reg2,
   input  logic [XLEN-1:0]   ext_imm,
   input  logic [XLEN-1:0]   pc,
   input  logic [XLEN-1:0]   mtvec,
   input  logic [XLEN-1:0]   mepc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   alu_res,
   output logic [XLEN-1:0]   branch_target,
   output logic [XLEN-1:0]   wdata,
   output logic              branch_taken,
   output logic              misaligned,
   output logic [MASK_W-1:0] wmask,
   output logic [1:0]        dbg_state
);
   localparam int SHW = $clog2(XLEN);
   localparam int OFW = $clog2(MASK_W);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_t;

   state_t state_q, state_d;
   logic              out_valid_q, out_valid_d, taken_q, taken_d, mis_q, mis_d;
   logic [XLEN-1:0]   res_q, res_d, target_q, target_d, wdata_q, wdata_d;
   logic [MASK_W-1:0] mask_q, mask_d;

   logic [XLEN-1:0]   op_a, op_b, alu_out, br_target;
   logic [SHW-1:0]    shamt;
   logic              br_taken, mis, accept;
   logic [MASK_W-1:0] mask;
   logic [OFW-1:0]    off;

   assign in_ready = (state_q == IDLE) || (state_q == HOLD && out_ready);
   assign accept   = in_valid && in_ready && !flush;

   // ALU: operand selection and the arithmetic/logic result
   always_comb begin
      op_a = '0;
      op_b = '0;
      case (alu_srca)
         2'b00:   op_a = data_reg1;
         2'b10:   op_a = pc;
         default: op_a = '0;
      endcase
      case (alu_srcb)
         2'b00:   op_b = data_reg2;
         2'b01:   op_b = ext_imm;
         2'b10:   op_b = data_reg2 & XLEN'(XLEN - 1);
         default: op_b = '0;
      endcase
      shamt = op_b[SHW-1:0];
      case (alu_ctrl)
         4'd0:    alu_out = op_a + op_b;
         4'd1:    alu_out = op_a - op_b;
         4'd2:    alu_out = op_a << shamt;
         4'd3:    alu_out = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         4'd4:    alu_out = {{(XLEN-1){1'b0}}, op_a < op_b};
         4'd5:    alu_out = op_a ^ op_b;
         4'd6:    alu_out = op_a >> shamt;
         4'd7:    alu_out = $signed(op_a) >>> shamt;
         4'd8:    alu_out = op_a | op_b;
         4'd9:    alu_out = op_a & op_b;
         4'd10:   alu_out = op_b;
         default: alu_out = '0;
      endcase
   end

   // Branch decision from the compare result the decoder chose (SUB/SLT/SLTU) and target
   always_comb begin
      br_taken  = 1'b0;
      br_target = pc + ext_imm;
      case (branch_type)
         4'd1:  br_taken = 1'b1;
         4'd2: begin
            br_taken  = 1'b1;
            br_target = (data_reg1 + ext_imm) & ~XLEN'(1);
         end
         4'd3:  br_taken = (alu_out == '0);
         4'd4:  br_taken = (alu_out != '0);
         4'd5, 4'd7: br_taken = alu_out[0];
         4'd6, 4'd8: br_taken = !alu_out[0];
         4'd9: begin
            br_taken  = 1'b1;
            br_target = mtvec;
         end
         4'd10: begin
            br_taken  = 1'b1;
            br_target = mepc;
         end
         default: br_taken = 1'b0;
      endcase
   end

   // Store byte mask and misalignment check on the ALU address
   always_comb begin
      off  = alu_out[OFW-1:0];
      mask = '0;
      mis  = 1'b0;
      case (mem_width)
         3'b000: mask = MASK_W'(1) << off;
         3'b001: if (off[0]) mis = 1'b1; else mask = MASK_W'(3) << off;
         3'b010: if (off[1:0] != 2'b00) mis = 1'b1; else mask = MASK_W'(15) << off;
         3'b011: if (XLEN == 64) begin
            if (off != '0) mis = 1'b1; else mask = '1;
         end
         default: mask = '0;
      endcase
   end

`ifdef EXU_MDU_EN
   localparam int CW = $clog2(XLEN + 1);
   logic [2*XLEN:0]   acc_q, acc_d, step_acc, shifted;
   logic [XLEN-1:0]   dvsr_q, dvsr_d, a_mag, b_mag, spec_res, fin_res, q_s, r_s;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic              neg_q, neg_d, rneg_q, rneg_d, sa, sb, spec_hit;
   logic [XLEN:0]     sum;
   logic [XLEN+1:0]   diff;
   logic [2*XLEN-1:0] prod_s;

   // MDU accept side: operand signs, magnitudes and the divide special cases
   always_comb begin
      sa = data_reg1[XLEN-1] && (mdu_op == 3'd1 || mdu_op == 3'd2 || mdu_op == 3'd4 || mdu_op == 3'd6);
      sb = data_reg2[XLEN-1] && (mdu_op == 3'd1 || mdu_op == 3'd4 || mdu_op == 3'd6);
      a_mag    = sa ? -data_reg1 : data_reg1;
      b_mag    = sb ? -data_reg2 : data_reg2;
      spec_hit = 1'b0;
      spec_res = '0;
      if (mdu_op[2]) begin
         if (data_reg2 == '0) begin
            spec_hit = 1'b1;
            spec_res = mdu_op[1] ? data_reg1 : '1;
         end else if (!mdu_op[0] && data_reg1 == {1'b1, {(XLEN-1){1'b0}}} && data_reg2 == '1) begin
            spec_hit = 1'b1;
            spec_res = mdu_op[1] ? '0 : data_reg1;
         end
      end
   end

   // One iteration: shift-add multiply or restoring divide, plus final sign fix-up
   always_comb begin
      sum     = acc_q[0] ? acc_q[2*XLEN:XLEN] + {1'b0, dvsr_q} : acc_q[2*XLEN:XLEN];
      shifted = {acc_q[2*XLEN-1:0], 1'b0};
      diff    = {1'b0, shifted[2*XLEN:XLEN]} - {2'b00, dvsr_q};
      if (!op_q[2])
         step_acc = {1'b0, sum, acc_q[XLEN-1:1]};
      else if (!diff[XLEN+1])
         step_acc = {diff[XLEN:0], shifted[XLEN-1:1], 1'b1};
      else
         step_acc = shifted;
      prod_s = neg_q ? -acc_q[2*XLEN-1:0] : acc_q[2*XLEN-1:0];
      q_s    = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      r_s    = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      if (!op_q[2])
         fin_res = (op_q == 3'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
      else
         fin_res = op_q[1] ? r_s : q_s;
   end
`else
   logic unused_mdu_op;
   assign unused_mdu_op = ^mdu_op;
`endif

   // Stage control: next state, result capture and MDU iteration
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      res_d       = res_q;
      target_d    = target_q;
      wdata_d     = wdata_q;
      taken_d     = taken_q;
      mis_d       = mis_q;
      mask_d      = mask_q;
`ifdef EXU_MDU_EN
      acc_d  = acc_q;
      dvsr_d = dvsr_q;
      cnt_d  = cnt_q;
      op_d   = op_q;
      neg_d  = neg_q;
      rneg_d = rneg_q;
`endif
      if (flush) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
      end else if (accept) begin
         state_d     = HOLD;
         out_valid_d = 1'b1;
         wdata_d     = data_reg2;
         res_d       = alu_out;
         target_d    = br_target;
         taken_d     = br_taken;
         mis_d       = mis;
         mask_d      = mask;
         if (is_mdu) begin
            res_d    = '0;
            target_d = '0;
            taken_d  = 1'b0;
            mis_d    = 1'b0;
            mask_d   = '0;
`ifdef EXU_MDU_EN
            if (spec_hit) begin
               res_d = spec_res;
            end else begin
               state_d     = BUSY;
               out_valid_d = 1'b0;
               acc_d       = {{(XLEN+1){1'b0}}, mdu_op[2] ? a_mag : b_mag};
               dvsr_d      = mdu_op[2] ? b_mag : a_mag;
               cnt_d       = CW'(XLEN);
               op_d        = mdu_op;
               neg_d       = sa ^ sb;
               rneg_d      = sa;
            end
`endif
         end
      end else if (state_q == HOLD && out_ready) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
`ifdef EXU_MDU_EN
      end else if (state_q == BUSY) begin
         if (cnt_q != '0) begin
            acc_d = step_acc;
            cnt_d = cnt_q - CW'(1);
         end else begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
            res_d       = fin_res;
         end
`endif
      end
   end

   // State and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         target_q    <= '0;
         wdata_q     <= '0;
         taken_q     <= 1'b0;
         mis_q       <= 1'b0;
         mask_q      <= '0;
`ifdef EXU_MDU_EN
         acc_q  <= '0;
         dvsr_q <= '0;
         cnt_q  <= '0;
         op_q   <= '0;
         neg_q  <= 1'b0;
         rneg_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         target_q    <= target_d;
         wdata_q     <= wdata_d;
         taken_q     <= taken_d;
         mis_q       <= mis_d;
         mask_q      <= mask_d;
`ifdef EXU_MDU_EN
         acc_q  <= acc_d;
         dvsr_q <= dvsr_d;
         cnt_q  <= cnt_d;
         op_q   <= op_d;
         neg_q  <= neg_d;
         rneg_q <= rneg_d;
`endif
      end
   end

   assign out_valid     = out_valid_q;
   assign alu_res       = res_q;
   assign branch_target = target_q;
   assign wdata         = wdata_q;
   assign branch_taken  = taken_q;
   assign misaligned    = mis_q;
   assign wmask         = mask_q;
   assign dbg_state     = state_q;
endmodule
